// File: rtl/math_pkg.sv
// Shared definitions for the iterative math primitives (squarer, square root, ...).
// Holds the common IDLE/BUSY/DONE state encoding and a counter-width helper.
package math_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } iter_state_t;

    // Width of an iteration counter that must reach n-1; never narrower than one bit.
    function automatic int itersize(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shift_add_step.sv
// One radix-2 shift-add multiply iteration, purely combinational.
// The accumulator picks up the multiplicand when the multiplier LSB is set;
// the multiplicand moves up one place and the multiplier down one place.
module shift_add_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [2*WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [2*WIDTH-1:0] mcand_next,
    output logic [WIDTH-1:0]   mplier_next
);

    // Conditional add plus the two operand shifts for this bit position.
    always_comb begin
        acc_next    = mplier[0] ? (acc + mcand) : acc;
        mcand_next  = mcand << 1;
        mplier_next = mplier >> 1;
    end

endmodule

// File: rtl/fp_square.sv
// Sequential unsigned fixed-point squarer: out = in*in over WIDTH shift-add
// cycles, truncated to INT_WIDTH.FRAC_WIDTH, with a one-cycle done pulse.
// Optional build macro FP_SQUARE_SATURATE_EN: on overflow, out is forced to
// all ones instead of wrapping; overflow is reported either way.
//
// state | meaning
// IDLE  | waiting for go; operands loaded when go is seen
// BUSY  | one shift-add iteration per cycle, WIDTH cycles in total
// DONE  | done pulses for this single cycle, then back to IDLE
module fp_square
    import math_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int INT_WIDTH  = 16,
    parameter int FRAC_WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             done,
    output logic             overflow
);

    localparam int            CW   = itersize(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    generate
        if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_format
            $error("fp_square: INT_WIDTH + FRAC_WIDTH must equal WIDTH");
        end
    endgenerate

    iter_state_t        state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      count_q;

    logic [2*WIDTH-1:0] acc_s, mcand_s;
    logic [WIDTH-1:0]   mplier_s;

    logic               last_iter;
    logic [2*WIDTH-1:0] prod_shift;
    logic               ovf_calc;
    logic [WIDTH-1:0]   res_final;

    logic [WIDTH-1:0]   out_q;
    logic               done_q, ovf_q;

    shift_add_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc_q),
        .mcand       (mcand_q),
        .mplier      (mplier_q),
        .acc_next    (acc_s),
        .mcand_next  (mcand_s),
        .mplier_next (mplier_s)
    );

    // The step output on the final iteration is the exact product. Shifting the
    // whole product keeps every bit in play: the low word is the result, anything
    // above it is integer overflow (always zero when FRAC_WIDTH == WIDTH).
    assign last_iter  = (state_q == BUSY) && (count_q == LAST);
    assign prod_shift = acc_s >> FRAC_WIDTH;
    assign ovf_calc   = |prod_shift[2*WIDTH-1:WIDTH];

`ifdef FP_SQUARE_SATURATE_EN
    assign res_final = ovf_calc ? '1 : prod_shift[WIDTH-1:0];
`else
    assign res_final = prod_shift[WIDTH-1:0];
`endif

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; go only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (go) state_d = BUSY;
            BUSY:    if (count_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand load on go, then one shift-add step per BUSY cycle; the counter
    // holds at its last value rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (go) begin
                        acc_q    <= '0;
                        mcand_q  <= {{WIDTH{1'b0}}, in};
                        mplier_q <= in;
                        count_q  <= '0;
                    end
                end
                BUSY: begin
                    acc_q    <= acc_s;
                    mcand_q  <= mcand_s;
                    mplier_q <= mplier_s;
                    if (count_q != LAST) count_q <= count_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Result latch: out/overflow only change on the edge into DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q  <= '0;
            ovf_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= last_iter;
            if (last_iter) begin
                out_q <= res_final;
                ovf_q <= ovf_calc;
            end
        end
    end

    assign out      = out_q;
    assign done     = done_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_fp_square.sv
// Scoreboard bench for fp_square: a 32-bit Q16.16 instance and an 8-bit
// integer instance. Stimulus pushes hand-computed results; a negedge monitor
// pops and compares whenever done is seen.
module tb_fp_square;

    logic        clk = 1'b0;
    logic        reset;
    logic        go32, go8;
    logic [31:0] in32, out32;
    logic [7:0]  in8, out8;
    logic        done32, ovf32, done8, ovf8;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fp_square #(.WIDTH(32), .INT_WIDTH(16), .FRAC_WIDTH(16)) dut32 (
        .clk(clk), .reset(reset), .go(go32), .in(in32),
        .out(out32), .done(done32), .overflow(ovf32)
    );

    fp_square #(.WIDTH(8), .INT_WIDTH(8), .FRAC_WIDTH(0)) dut8 (
        .clk(clk), .reset(reset), .go(go8), .in(in8),
        .out(out8), .done(done8), .overflow(ovf8)
    );

    typedef struct {
        logic [31:0] out;
        logic        ovf;
        int          cyc;
        string       name;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];

    int n_pass = 0;
    int n_total = 0;
    int tmo_req = 0;
    int tmo_seen = 0;

    // Q16.16 vectors: operand, wrapped result, overflow
    localparam logic [31:0] V32_IN  [9] = '{32'h0003_0000, 32'h0001_8000, 32'h0000_0001,
                                            32'h0001_0000, 32'h0000_FFFF, 32'h00FF_FFFF,
                                            32'h0100_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    localparam logic [31:0] V32_OUT [9] = '{32'h0009_0000, 32'h0002_4000, 32'h0000_0000,
                                            32'h0001_0000, 32'h0000_FFFE, 32'hFFFF_FE00,
                                            32'h0000_0000, 32'hFFFE_0000, 32'h0000_0000};
    localparam logic        V32_OVF [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Integer 8-bit vectors
    localparam logic [7:0]  V8_IN  [4] = '{8'd15, 8'd16, 8'd255, 8'd0};
    localparam logic [7:0]  V8_OUT [4] = '{8'd225, 8'd0, 8'h01, 8'd0};
    localparam logic        V8_OVF [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

    function automatic logic [31:0] expv(input logic [31:0] wrap, input logic ov,
                                         input logic [31:0] ones);
        logic sat;
`ifdef FP_SQUARE_SATURATE_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        return (sat && ov) ? ones : wrap;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual %h required %h", nm, act, req);
    endtask

    // Monitor: reset-state checks while reset is low, scoreboard pops on done.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_out32", out32, 32'h0);
                chk("rst_done32", {31'b0, done32}, 32'h0);
                chk("rst_ovf32", {31'b0, ovf32}, 32'h0);
                chk("rst_out8", {24'b0, out8}, 32'h0);
                chk("rst_done8", {31'b0, done8}, 32'h0);
            end
            if (done32) begin
                if (q32.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done32: actual done=1 at cycle %0d required no pending result", cyc);
                end else begin
                    e = q32.pop_front();
                    chk({e.name, "_out"}, out32, e.out);
                    chk({e.name, "_ovf"}, {31'b0, ovf32}, {31'b0, e.ovf});
                    chk({e.name, "_cyc"}, cyc, e.cyc);
                end
            end
            if (done8) begin
                if (q8.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done8: actual done=1 at cycle %0d required no pending result", cyc);
                end else begin
                    e = q8.pop_front();
                    chk({e.name, "_out"}, {24'b0, out8}, e.out);
                    chk({e.name, "_ovf"}, {31'b0, ovf8}, {31'b0, e.ovf});
                    chk({e.name, "_cyc"}, cyc, e.cyc);
                end
            end
            if (tmo_req != tmo_seen) begin
                n_total += tmo_req - tmo_seen;
                tmo_seen = tmo_req;
            end
        end
    end

    // Pulse go for one cycle; the result is due WIDTH+1 cycles after the go cycle.
    task automatic issue32(input logic [31:0] v, input logic [31:0] wrap, input logic ov,
                           input string nm, input bit push);
        go32 = 1'b1;
        in32 = v;
        if (push) q32.push_back('{expv(wrap, ov, 32'hFFFF_FFFF), ov, cyc + 33, nm});
        @(posedge clk);
        #1;
        go32 = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] v, input logic [7:0] wrap, input logic ov,
                          input string nm);
        go8 = 1'b1;
        in8 = v;
        q8.push_back('{expv({24'b0, wrap}, ov, 32'h0000_00FF), ov, cyc + 9, nm});
        @(posedge clk);
        #1;
        go8 = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (q32.size() != 0 || q8.size() != 0) begin
            $display("FAIL timeout: actual %0d results pending required 0 after %0d cycles",
                     q32.size() + q8.size(), budget);
            q32.delete();
            q8.delete();
            tmo_req++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        go32 = 1'b0; in32 = '0;
        go8 = 1'b0;  in8 = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            issue32(V32_IN[i], V32_OUT[i], V32_OVF[i], $sformatf("v32_%0d", i), 1'b1);
            wait_idle(60);
        end

        for (int i = 0; i < 4; i++) begin
            issue8(V8_IN[i], V8_OUT[i], V8_OVF[i], $sformatf("v8_%0d", i));
            wait_idle(30);
        end

        // Second go while busy is ignored.
        issue32(32'h0002_0000, 32'h0004_0000, 1'b0, "busy_prot", 1'b1);
        repeat (4) @(posedge clk);
        #1;
        issue32(32'h0005_0000, 32'h0, 1'b0, "ignored", 1'b0);
        wait_idle(60);

        // go held high: restart as soon as IDLE is re-entered.
        go32 = 1'b1;
        in32 = 32'h0002_0000;
        q32.push_back('{32'h0004_0000, 1'b0, cyc + 33, "held_a"});
        q32.push_back('{32'h0004_0000, 1'b0, cyc + 67, "held_b"});
        repeat (40) @(posedge clk);
        #1 go32 = 1'b0;
        wait_idle(100);

        // Reset mid-operation: no done, out back to 0, then a clean run.
        issue32(32'h0002_0000, 32'h0, 1'b0, "aborted", 1'b0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        issue32(32'h0002_0000, 32'h0004_0000, 1'b0, "post_rst", 1'b1);
        wait_idle(60);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual simulation time exceeded required bound");
        $fatal(1);
    end

endmodule

// File: doc/fp_square.md
# fp_square

Sequential unsigned fixed-point squarer, the inverse companion to the iterative square-root primitive in the math primitives library. It accepts one operand on a `go` pulse, computes `in*in` with a radix-2 shift-add datapath over WIDTH cycles, and presents a truncated fixed-point result with a one-cycle `done` pulse. Integer squaring is the FRAC_WIDTH=0 instance.

## Interface
- WIDTH, 32, operand/result width in bits
- INT_WIDTH, 16, integer bits of operand and result
- FRAC_WIDTH, 16, fractional bits; INT_WIDTH+FRAC_WIDTH must equal WIDTH (elaboration error otherwise)

- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset (asserted at 0)
- go  in  1  start request, sampled in IDLE only
- in  in  WIDTH  unsigned fixed-point operand, sampled with go
- out  out  WIDTH  squared result, registered, held until next completion
- done  out  1  one-cycle completion pulse
- overflow  out  1  result exceeded INT_WIDTH integer bits, valid with out

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: go=1 -> load mcand={WIDTH'0,in} (2*WIDTH bits), mplier=in, acc=0, count=0; go to BUSY. go=0 -> stay.
- BUSY, each cycle: if mplier[0] then acc += mcand; mcand <<= 1; mplier >>= 1; count += 1. After WIDTH iterations (count==WIDTH-1 step) -> DONE, registering out and overflow from the final product P.
- DONE: done=1 for exactly this cycle; unconditionally -> IDLE.
- Arithmetic: P is 2*WIDTH bits, exact. Result = P[WIDTH+FRAC_WIDTH-1 : FRAC_WIDTH]; lower FRAC_WIDTH bits truncated (round toward zero). overflow = OR of P[2*WIDTH-1 : WIDTH+FRAC_WIDTH]; always 0 when FRAC_WIDTH=WIDTH.
- go and in ignored in BUSY and DONE; no queueing. go held high restarts immediately on return to IDLE.
- count width $clog2(WIDTH); no wrap beyond WIDTH-1.
- Reset values: state=IDLE, out=0, done=0, overflow=0, acc/mcand/mplier/count=0.
- Reset mid-operation: computation discarded, no done pulse, out returns to 0.

## Timing
- Cycle 0: go=1 in IDLE. Cycles 1..WIDTH: BUSY. Cycle WIDTH+1: DONE, done=1, out/overflow valid.
- Latency go-to-done: WIDTH+1 cycles. Initiation interval with go held high: WIDTH+2 cycles.
- out and overflow change only on the edge entering DONE (or on reset); stable otherwise.
- No combinational path from inputs to outputs.

## Configuration
- FP_SQUARE_SATURATE_EN defined: when overflow=1, out = all ones (max representable); overflow still reported.
- Undefined: out = truncated slice of P (wraps modulo 2^(INT_WIDTH)); overflow still reported.

## Structure
- Shared package `math_pkg`: state typedef (IDLE/BUSY/DONE enum) reusable by other iterative math primitives; `itersize` helper constant function for counter widths.
- Sub-module `shift_add_step`: combinational single iteration (acc, mcand, mplier in -> next values out), parameterised by WIDTH; instantiated once.
- Top holds FSM, counter, operand registers, result latch, saturation logic.

## Test plan
- WIDTH=32/FRAC=16: in=0x00030000 (3.0) -> done in cycle 33, out=0x00090000, overflow=0; in=0x00018000 (1.5) -> out=0x00024000.
- Truncation: in=0x00000001 (2^-16) -> out=0x00000000, overflow=0; in=0x00010000 -> out=0x00010000.
- Overflow: in=0x01000000 (256.0) -> overflow=1; out=0xFFFFFFFF with FP_SQUARE_SATURATE_EN, out=0x00000000 without.
- Busy protection: go with 0x00020000, second go at cycle 5 with 0x00050000 -> single done at cycle 33, out=0x00040000; go held high -> next done at cycle 67.
- Reset: drive reset=0 at cycle 10 of a computation -> done never pulses, out=0, state IDLE; after release, go with 0x00020000 completes normally with out=0x00040000.
- Integer mode WIDTH=8/FRAC=0: in=15 -> out=225, overflow=0, done cycle 9; in=16 -> overflow=1.
